ddr_wr_buf: RTL and testbench
=============================

DDR_WR_BUF -- requirements
Module: ddr_wr_buf

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 32, DDR data width; the buffer word width is DQ_WIDTH*8 (256 bits).
REQ-002 SHALL have parameter H_WIDTH, default 1280, active pixels per line.
REQ-003 SHALL have parameter H_HEIGHT, default 720, active lines per frame.
REQ-004 SHALL have parameter BURST_LEN, default 16, words per AXI write burst.
REQ-005 SHALL have parameter FIFO_DEPTH, default 64, word FIFO depth (power of 2, at least 2*BURST_LEN).
REQ-006 SHALL use a single clock and asynchronous active-low reset: clk  input  1  sole clock, all logic on rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 vs_in  input  1  one-cycle frame-start pulse.
REQ-009 channel_in  input  2  source channel index of the incoming frame.
REQ-010 pix_vld  input  1  pix_data valid this cycle.
REQ-011 pix_data  input  16  RGB565 pixel.
REQ-012 buf_rd_en  input  1  AXI write side pops the head word.
REQ-013 buf_rd_data  output  DQ_WIDTH*8  head word of the FIFO, first-word-fall-through.
REQ-014 burst_ready  output  1  FIFO holds at least BURST_LEN words.
REQ-015 channel_sel  output  2  channel of the frame being buffered.
REQ-016 frame_end  output  1  one-cycle pulse when the last word of a frame is popped.
REQ-017 overflow  output  1  sticky flag: a word was dropped in the current frame.

Function
REQ-018 SHALL implement the FSM IDLE -> ACTIVE on vs_in, ACTIVE -> DRAIN when pixel H_WIDTH*H_HEIGHT is accepted, DRAIN -> IDLE when frame_end fires.
REQ-019 SHALL ignore pix_vld in IDLE and DRAIN.
REQ-020 SHALL pack 16 pixels per word, LSB first: pixel k of the word occupies bits [16k+15:16k].
REQ-021 SHALL push the completed word into the FIFO in the cycle the 16th pixel is accepted; the word SHALL be visible on buf_rd_data one cycle later if the FIFO was empty.
REQ-022 SHALL produce H_WIDTH/16 = 80 words per line and 57600 words (3600 bursts) per frame at default parameters; H_WIDTH SHALL be a multiple of 16*BURST_LEN/H_WIDTH-compatible, i.e. the total word count SHALL be a multiple of BURST_LEN.
REQ-023 SHALL assert burst_ready combinationally from the FIFO count (count >= BURST_LEN).
REQ-024 The consumer pops exactly BURST_LEN words per burst; the block SHALL ignore buf_rd_en while the FIFO is empty.
REQ-025 On a simultaneous push and pop with a full FIFO, SHALL perform both and keep the count unchanged.
REQ-026 On a push with a full FIFO and no pop, SHALL drop the word, set overflow, and still advance the pixel counters.
REQ-027 SHALL latch channel_in into channel_sel on vs_in and hold it until the next vs_in.
REQ-028 On vs_in in ACTIVE or DRAIN: SHALL discard the partial pack register, clear the pixel and word counters, clear overflow, flush the FIFO, latch channel_in, and enter ACTIVE in the next cycle.
REQ-029 A pixel with pix_vld coincident with vs_in SHALL be taken as pixel 0 of the new frame.
REQ-030 SHALL assert frame_end for one cycle on the pop of word 57600 of the frame.

Reset
REQ-031 On rst low: FSM = IDLE, FIFO empty, counters = 0, burst_ready = 0, channel_sel = 0, frame_end = 0, overflow = 0, buf_rd_data = 0.
REQ-032 Reset mid-burst SHALL discard all buffered data; no partial-burst completion is required.

Structure
REQ-033 Shared package video_buf_pkg SHALL hold PIX_PER_WORD = 16, the default line and frame geometry, and the FSM state encoding, shared with ddr_rd_buf.
REQ-034 The FIFO SHALL be a sub-module sync_fifo_fwft (width, depth parameters, count output); packing and the FSM live in ddr_wr_buf.

Verification
REQ-035 Stream pixels 0x0000..0x000F continuously after vs_in -> buf_rd_data = 0x000F000E...00010000 one cycle after the 16th pixel.
REQ-036 Push 16 words without popping -> burst_ready rises in the cycle after the 256th pixel; 16 pops -> burst_ready = 0 and the FIFO is empty.
REQ-037 Full 1280x720 frame with a channel_in = 2 latch and an always-ready consumer -> exactly 3600 bursts, channel_sel = 2 throughout, a single frame_end on the final pop, overflow = 0.
REQ-038 Consumer stalled until 65 words are produced -> overflow = 1, FIFO count stays 64, frame_end still fires after 57600 pixel-words of counting.
REQ-039 vs_in after 100 pixels of a frame -> FIFO flushed, the partial word discarded, the next 16 pixels form word 0 of the new frame.
REQ-040 Assert rst low while a burst is popping -> all outputs return to their REQ-031 values immediately; operation resumes normally after the next vs_in.

Source files
------------

// File: rtl/video_buf_pkg.sv
// ============================================================================
// video_buf_pkg : geometry defaults and FSM encoding shared by DDR buffers
// Revision 1.0
// ============================================================================
`default_nettype none

package video_buf_pkg;
    localparam int PIX_BITS     = 16;
    localparam int PIX_PER_WORD = 16;
    localparam int H_WIDTH_DEF  = 1280;
    localparam int H_HEIGHT_DEF = 720;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } buf_state_e;
endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// sync_fifo_fwft : first-word-fall-through FIFO with flush, count and drop
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo_fwft #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q;
    logic [c_AW-1:0]  rd_ptr_q;
    logic [c_AW:0]    count_q;
    logic             w_pop;
    logic             w_push;
    logic             w_empty;

    assign w_empty   = (count_q == '0);
    assign w_pop     = rd_en_i && !w_empty && !flush_i;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push    = wr_en_i && !flush_i && ((count_q != (c_AW+1)'(DEPTH)) || w_pop);
    assign drop_o    = wr_en_i && !flush_i && !w_push;
    assign rd_data_o = w_empty ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (c_AW+1)'(1);
                2'b01:   count_q <= count_q - (c_AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

`default_nettype wire

// File: rtl/ddr_wr_buf.sv
// ============================================================================
// ddr_wr_buf : packs RGB565 pixels into DDR words and buffers them for AXI
// Revision 1.0
// ============================================================================
`default_nettype none

module ddr_wr_buf
    import video_buf_pkg::*;
#(
    parameter int DQ_WIDTH   = 32,
    parameter int H_WIDTH    = H_WIDTH_DEF,
    parameter int H_HEIGHT   = H_HEIGHT_DEF,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vs_in,
    input  logic [1:0]              channel_in,
    input  logic                    pix_vld,
    input  logic [15:0]             pix_data,
    input  logic                    buf_rd_en,
    output logic [DQ_WIDTH*8-1:0]   buf_rd_data,
    output logic                    burst_ready,
    output logic [1:0]              channel_sel,
    output logic                    frame_end,
    output logic                    overflow
);
    localparam int c_WORD_W      = DQ_WIDTH * 8;
    localparam int c_PPW         = c_WORD_W / PIX_BITS;
    localparam int c_IDX_W       = $clog2(c_PPW);
    localparam int c_WORDS_TOTAL = (H_WIDTH * H_HEIGHT) / c_PPW;
    localparam int c_WC_W        = $clog2(c_WORDS_TOTAL + 1);
    localparam int c_CNT_W       = $clog2(FIFO_DEPTH) + 1;

    buf_state_e           state_q, state_d;
    logic [c_IDX_W-1:0]   pix_idx_q, pix_idx_d;
    logic [c_WC_W-1:0]    word_cnt_q, word_cnt_d;
    logic [c_WORD_W-1:0]  pack_q, pack_d;
    logic [1:0]           chan_q, chan_d;
    logic                 ovf_q, ovf_d;

    logic                 w_accept;
    logic                 w_push;
    logic                 w_drop;
    logic [c_WORD_W-1:0]  w_word;
    logic [c_CNT_W-1:0]   w_count;

    // A pixel arriving with vs_in belongs to the new frame, so it is not packed here.
    assign w_accept = pix_vld && (state_q == ST_ACTIVE) && !vs_in;
    assign w_push   = w_accept && (pix_idx_q == c_IDX_W'(c_PPW - 1));

    always_comb begin
        w_word = pack_q;
        w_word[int'(pix_idx_q) * PIX_BITS +: PIX_BITS] = pix_data;
    end

    sync_fifo_fwft #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .flush_i   (vs_in),
        .wr_en_i   (w_push),
        .wr_data_i (w_word),
        .rd_en_i   (buf_rd_en),
        .rd_data_o (buf_rd_data),
        .count_o   (w_count),
        .drop_o    (w_drop)
    );

    assign burst_ready = (w_count >= c_CNT_W'(BURST_LEN));
    assign frame_end   = (state_q == ST_DRAIN) && !vs_in && buf_rd_en && (w_count == c_CNT_W'(1));
    assign channel_sel = chan_q;
    assign overflow    = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pix_idx_q  <= '0;
            word_cnt_q <= '0;
            pack_q     <= '0;
            chan_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_idx_q  <= pix_idx_d;
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            chan_q     <= chan_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pix_idx_d  = pix_idx_q;
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        chan_d     = chan_q;
        ovf_d      = ovf_q;

        if (vs_in) begin
            state_d    = ST_ACTIVE;
            chan_d     = channel_in;
            ovf_d      = 1'b0;
            word_cnt_d = '0;
            pack_d     = '0;
            pix_idx_d  = '0;
            if (pix_vld) begin
                pack_d[PIX_BITS-1:0] = pix_data;
                pix_idx_d            = c_IDX_W'(1);
            end
        end else begin
            if (w_accept) begin
                pack_d = w_word;
                if (w_push) begin
                    pix_idx_d  = '0;
                    word_cnt_d = word_cnt_q + c_WC_W'(1);
                    if (word_cnt_q == c_WC_W'(c_WORDS_TOTAL - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    pix_idx_d = pix_idx_q + c_IDX_W'(1);
                end
            end
            if (w_drop) begin
                ovf_d = 1'b1;
            end
            if (frame_end) begin
                state_d = ST_IDLE;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ddr_wr_buf.sv
// ============================================================================
// tb_ddr_wr_buf : scoreboard bench for ddr_wr_buf on a reduced 256x8 frame
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ddr_wr_buf;
    localparam int DQ_WIDTH   = 32;
    localparam int H_WIDTH    = 256;
    localparam int H_HEIGHT   = 8;
    localparam int BURST_LEN  = 16;
    localparam int FIFO_DEPTH = 64;
    localparam int W          = DQ_WIDTH * 8;
    localparam int WORDS      = H_WIDTH * H_HEIGHT / 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vs_in = 1'b0;
    logic [1:0]    channel_in = '0;
    logic          pix_vld = 1'b0;
    logic [15:0]   pix_data = '0;
    logic          buf_rd_en = 1'b0;
    logic [W-1:0]  buf_rd_data;
    logic          burst_ready;
    logic [1:0]    channel_sel;
    logic          frame_end;
    logic          overflow;

    always #5 clk = ~clk;

    ddr_wr_buf #(
        .DQ_WIDTH   (DQ_WIDTH),
        .H_WIDTH    (H_WIDTH),
        .H_HEIGHT   (H_HEIGHT),
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vs_in       (vs_in),
        .channel_in  (channel_in),
        .pix_vld     (pix_vld),
        .pix_data    (pix_data),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_data (buf_rd_data),
        .burst_ready (burst_ready),
        .channel_sel (channel_sel),
        .frame_end   (frame_end),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 active, 2 drain; mq is the expected FIFO content.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_pack;
    int           m_pi, m_wc, m_st;
    logic         m_ovf;
    logic [1:0]   m_ch;
    int           fe_seen;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pack = '0;
        m_pi = 0; m_wc = 0; m_st = 0;
        m_ovf = 1'b0; m_ch = 2'd0;
    endtask

    task automatic step(input logic vs, input logic [1:0] ch, input logic vld,
                        input logic [15:0] pix, input logic rd);
        logic         exp_fe;
        logic         have_word;
        logic [W-1:0] word;
        vs_in = vs; channel_in = ch; pix_vld = vld; pix_data = pix; buf_rd_en = rd;
        #1;
        exp_fe = (m_st == 2) && rd && (mq.size() == 1) && !vs;
        chk("frame_end", frame_end, exp_fe);
        chk("burst_ready", burst_ready, mq.size() >= BURST_LEN);
        chk("overflow", overflow, m_ovf);
        chk("channel_sel", channel_sel, m_ch);
        if (rd && !vs && mq.size() > 0) chk("rd_data", buf_rd_data, mq[0]);
        if (frame_end) fe_seen++;
        @(posedge clk);
        have_word = 1'b0;
        word = '0;
        if (vs) begin
            mq.delete();
            m_ovf = 1'b0; m_ch = ch; m_wc = 0; m_st = 1; m_pack = '0; m_pi = 0;
            if (vld) begin m_pack[15:0] = pix; m_pi = 1; end
        end else begin
            if (m_st == 1 && vld) begin
                m_pack[m_pi*16 +: 16] = pix;
                if (m_pi == 15) begin
                    have_word = 1'b1; word = m_pack; m_pi = 0; m_wc++;
                    if (m_wc == WORDS) m_st = 2;
                end else m_pi++;
            end
            if (rd && mq.size() > 0) void'(mq.pop_front());
            if (have_word) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(word);
                else m_ovf = 1'b1;
            end
            if (exp_fe) m_st = 0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] ch;
        bit         vs_pix;
        int         npix;
        bit         cons_on;
        int         post_pops;
        bit         post_vld;
        bit         exp_br;
        bit         exp_ovf;
        int         exp_fe;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [W-1:0] exp_word;

        tbl[0] = '{2'd1, 1'b0,   16, 1'b0,  0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{2'd3, 1'b1,  255, 1'b0,  0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2] = '{2'd0, 1'b0,  256, 1'b0,  0, 1'b0, 1'b1, 1'b0, 0};
        tbl[3] = '{2'd2, 1'b1,  256, 1'b0, 18, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{2'd1, 1'b0,  100, 1'b0,  0, 1'b0, 1'b0, 1'b0, 0};
        tbl[5] = '{2'd2, 1'b1, 1040, 1'b0,  0, 1'b0, 1'b1, 1'b1, 0};
        tbl[6] = '{2'd3, 1'b0, 2048, 1'b1,  1, 1'b1, 1'b0, 1'b0, 1};
        tbl[7] = '{2'd0, 1'b1, 2048, 1'b0, 66, 1'b1, 1'b0, 1'b1, 1};

        model_reset();
        fe_seen = 0;
        repeat (2) @(negedge clk);
        chk("reset buf_rd_data", buf_rd_data, '0);
        chk("reset burst_ready", burst_ready, 1'b0);
        chk("reset channel_sel", channel_sel, 2'd0);
        chk("reset frame_end", frame_end, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Incrementing pixels land LSB-first in the first word.
        step(1'b1, 2'd1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 16; k++) step(1'b0, 2'd1, 1'b1, 16'(k), 1'b0);
        exp_word = '0;
        for (int k = 0; k < 16; k++) exp_word[k*16 +: 16] = 16'(k);
        chk("ramp word", buf_rd_data, exp_word);

        for (int i = 0; i < 8; i++) begin
            fe_seen = 0;
            step(1'b1, tbl[i].ch, tbl[i].vs_pix, 16'($urandom_range(0, 65535)), 1'b0);
            for (int p = 0; p < tbl[i].npix - int'(tbl[i].vs_pix); p++)
                step(1'b0, ~tbl[i].ch, 1'b1, 16'($urandom_range(0, 65535)),
                     tbl[i].cons_on && (mq.size() > 0));
            for (int p = 0; p < tbl[i].post_pops; p++)
                step(1'b0, ~tbl[i].ch, tbl[i].post_vld, 16'($urandom_range(0, 65535)), 1'b1);
            chk($sformatf("vec%0d burst_ready", i), burst_ready, tbl[i].exp_br);
            chk($sformatf("vec%0d overflow", i), overflow, tbl[i].exp_ovf);
            chk($sformatf("vec%0d channel_sel", i), channel_sel, tbl[i].ch);
            chk($sformatf("vec%0d frame_end count", i), W'(fe_seen), W'(tbl[i].exp_fe));
        end

        // Reset asserted while a burst is being popped.
        step(1'b1, 2'd2, 1'b0, 16'h0, 1'b0);
        for (int p = 0; p < 256; p++) step(1'b0, 2'd2, 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
        for (int p = 0; p < 5; p++) step(1'b0, 2'd2, 1'b0, 16'h0, 1'b1);
        buf_rd_en = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("midreset buf_rd_data", buf_rd_data, '0);
        chk("midreset burst_ready", burst_ready, 1'b0);
        chk("midreset channel_sel", channel_sel, 2'd0);
        chk("midreset frame_end", frame_end, 1'b0);
        chk("midreset overflow", overflow, 1'b0);
        model_reset();
        @(negedge clk);
        buf_rd_en = 1'b0;
        rst = 1'b1;
        for (int p = 0; p < 20; p++) step(1'b0, 2'd1, 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
        step(1'b1, 2'd2, 1'b1, 16'h1234, 1'b0);
        for (int p = 0; p < 15; p++) step(1'b0, 2'd0, 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
        step(1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
        chk("post-reset channel_sel", channel_sel, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
